alu_sequencer: RTL and testbench

Operand-issue and writeback controller on the driving side of the 6502 core's registered ALU. It accepts one ALU request at a time over a valid/ready handshake and selects operands from the A/X/Y registers or an immediate. It presents the opcode and operands to the ALU, then captures the ALU's registered result and flags one cycle later. The result is written back to the architectural registers, and the flag bits named by a per-request mask are merged into the status register.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one ALU request at a time to a registered ALU
// and writes the result and masked flags back to A/X/Y/P.
module alu_sequencer #(
  parameter logic [6:0] P_RESET = 7'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_op,
  input  logic [1:0] req_src_a,
  input  logic [1:0] req_src_b,
  input  logic [7:0] req_imm,
  input  logic [1:0] req_dst,
  input  logic [6:0] req_flag_mask,
  output logic [4:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic [6:0] alu_flags,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       done,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [6:0] status
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [1:0] dst_q, dst_d;
  logic [6:0] mask_q, mask_d;
  logic [7:0] a_q, a_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [6:0] p_q, p_d;
  logic       accept;

  function automatic logic [7:0] pick(
    input logic [1:0] sel,
    input logic [7:0] a,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] imm
  );
    logic [7:0] v;
    unique case (sel)
      2'd0:    v = a;
      2'd1:    v = x;
      2'd2:    v = y;
      default: v = imm;
    endcase
    return v;
  endfunction

  assign accept = (state_q == S_IDLE) && req_valid;

  // Next-state logic: IDLE -> ISSUE -> WB -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_valid) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture opcode, operands and writeback controls on accept
  always_comb begin
    op_d   = op_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    dst_d  = dst_q;
    mask_d = mask_q;
    if (accept) begin
      op_d   = req_op;
      opa_d  = pick(req_src_a, a_q, x_q, y_q, req_imm);
      opb_d  = pick(req_src_b, a_q, x_q, y_q, req_imm);
      dst_d  = req_dst;
      mask_d = req_flag_mask;
    end
  end

  // Architectural regs: external write first, ALU writeback overrides
  always_comb begin
    a_d = a_q;
    x_d = x_q;
    y_d = y_q;
    p_d = p_q;
    if (wr_en) begin
      unique case (wr_sel)
        2'd0:    a_d = wr_data;
        2'd1:    x_d = wr_data;
        2'd2:    y_d = wr_data;
        default: p_d = wr_data[6:0];
      endcase
    end
    if (state_q == S_WB) begin
      unique case (dst_q)
        2'd0:    a_d = alu_result;
        2'd1:    x_d = alu_result;
        2'd2:    y_d = alu_result;
        default: ;
      endcase
      p_d = (p_d & ~mask_q) | (alu_flags & mask_q);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      dst_q   <= '0;
      mask_q  <= '0;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= P_RESET;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dst_q   <= dst_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_WB);
  assign alu_op    = op_q;
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign reg_a     = a_q;
  assign reg_x     = x_q;
  assign reg_y     = y_q;
  assign status    = p_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with a behavioural registered
// ALU and checks directed scenarios plus randomized transactions.
module tb_alu_sequencer;

  localparam logic [4:0] OP_ASL = 5'd0;
  localparam logic [4:0] OP_LSR = 5'd1;
  localparam logic [4:0] OP_ROL = 5'd2;
  localparam logic [4:0] OP_ROR = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_INC = 5'd6;
  localparam logic [4:0] OP_DEC = 5'd7;
  localparam logic [4:0] OP_CMP = 5'd8;
  localparam logic [4:0] OP_FLG = 5'd9;
  localparam int FC = 0;
  localparam int FZ = 1;
  localparam int FN = 6;
  localparam logic [6:0] MC = 7'h01;
  localparam logic [6:0] MZ = 7'h02;
  localparam logic [6:0] MN = 7'h40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_op = '0;
  logic [1:0] req_src_a = '0;
  logic [1:0] req_src_b = '0;
  logic [7:0] req_imm = '0;
  logic [1:0] req_dst = '0;
  logic [6:0] req_flag_mask = '0;
  logic [4:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result = '0;
  logic [6:0] alu_flags = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic [7:0] wr_data = '0;
  logic       done;
  logic [7:0] reg_a;
  logic [7:0] reg_x;
  logic [7:0] reg_y;
  logic [6:0] status;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.P_RESET(7'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_src_a(req_src_a),
    .req_src_b(req_src_b),
    .req_imm(req_imm),
    .req_dst(req_dst),
    .req_flag_mask(req_flag_mask),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_result(alu_result),
    .alu_flags(alu_flags),
    .wr_en(wr_en),
    .wr_sel(wr_sel),
    .wr_data(wr_data),
    .done(done),
    .reg_a(reg_a),
    .reg_x(reg_x),
    .reg_y(reg_y),
    .status(status)
  );

  always #5 clk = ~clk;

  // ALU behaviour: {flags, result}; carry-in for rotates is b[0]
  function automatic logic [14:0] alu_fn(
    input logic [4:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] d;
    logic [6:0] f;
    logic       c;
    r = a;
    f = '0;
    c = 1'b0;
    d = a - b;
    case (op)
      OP_ASL: begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_LSR: begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_ROL: begin r = {a[6:0], b[0]}; c = a[7]; end
      OP_ROR: begin r = {b[0], a[7:1]}; c = a[0]; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_INC: r = a + 8'd1;
      OP_DEC: r = a - 8'd1;
      OP_CMP: begin r = a; c = (a < b); end
      default: r = a;
    endcase
    f[FC] = c;
    f[FZ] = (r == 8'h00);
    f[FN] = r[7];
    if (op == OP_CMP) begin
      f[FZ] = (a == b);
      f[FN] = d[7];
    end
    if (op == OP_FLG) f = b[6:0];
    return {f, r};
  endfunction

  // Registered ALU: result appears one cycle after its inputs
  always @(posedge clk) begin
    {alu_flags, alu_result} <= alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic ext_write(input logic [1:0] s, input logic [7:0] d);
    wr_sel = s;
    wr_data = d;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // One request from IDLE; optional external write during WB.
  // lat = cycle index (accept edge = 0) in which done was seen.
  task automatic do_req(
    input  logic [4:0] op,
    input  logic [1:0] sa,
    input  logic [1:0] sb,
    input  logic [7:0] imm,
    input  logic [1:0] dst,
    input  logic [6:0] mask,
    input  logic       wbwe,
    input  logic [1:0] wbsel,
    input  logic [7:0] wbdat,
    output int         lat
  );
    req_op = op;
    req_src_a = sa;
    req_src_b = sb;
    req_imm = imm;
    req_dst = dst;
    req_flag_mask = mask;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done && wbwe) begin
      wr_en = 1'b1;
      wr_sel = wbsel;
      wr_data = wbdat;
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ext_write(2'd0, 8'h12);
    ext_write(2'd1, 8'h34);
    ext_write(2'd2, 8'h56);
    ext_write(2'd3, 8'h2A);
    do_req(OP_OR, 2'd0, 2'd1, 8'h00, 2'd3, 7'h00, 1'b0, 2'd0, 8'h00, lat);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL rst_a got=%h exp=00", reg_a); end
    checks++; if (reg_x !== 8'h00) begin errors++; $display("FAIL rst_x got=%h exp=00", reg_x); end
    checks++; if (reg_y !== 8'h00) begin errors++; $display("FAIL rst_y got=%h exp=00", reg_y); end
    checks++; if (status !== 7'h00) begin errors++; $display("FAIL rst_p got=%h exp=00", status); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if ({alu_op, alu_a, alu_b} !== 21'h0) begin errors++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_asl();
    int lat;
    ext_write(2'd0, 8'h80);
    do_req(OP_ASL, 2'd0, 2'd0, 8'h00, 2'd0, MC | MZ | MN, 1'b0, 2'd0, 8'h00, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL asl_lat got=%0d exp=2", lat); end
    checks++; if (reg_a !== 8'h00) begin errors++; $display("FAIL asl_a got=%h exp=00", reg_a); end
    checks++; if (status !== 7'h03) begin errors++; $display("FAIL asl_p got=%h exp=03", status); end
  endtask

  task automatic test_inc_wrap();
    int lat;
    ext_write(2'd3, 7'h01);
    ext_write(2'd1, 8'hFF);
    do_req(OP_INC, 2'd1, 2'd0, 8'h00, 2'd1, MZ | MN, 1'b0, 2'd0, 8'h00, lat);
    checks++; if (reg_x !== 8'h00) begin errors++; $display("FAIL inc_x got=%h exp=00", reg_x); end
    checks++; if (status !== 7'h03) begin errors++; $display("FAIL inc_p got=%h exp=03", status); end
  endtask

  task automatic test_cmp();
    int lat;
    ext_write(2'd3, 7'h20);
    ext_write(2'd0, 8'h10);
    do_req(OP_CMP, 2'd3, 2'd0, 8'h10, 2'd3, MC | MZ | MN, 1'b0, 2'd0, 8'h00, lat);
    checks++; if (reg_a !== 8'h10) begin errors++; $display("FAIL cmp_a got=%h exp=10", reg_a); end
    checks++; if (status !== 7'h22) begin errors++; $display("FAIL cmp_p got=%h exp=22", status); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int dn;
    logic ok;
    dn = 0;
    ext_write(2'd0, 8'h01);
    req_op = OP_INC;
    req_src_a = 2'd0;
    req_src_b = 2'd0;
    req_dst = 2'd0;
    req_flag_mask = MZ | MN;
    req_valid = 1'b1;
    for (int e = 0; e < 8; e++) begin
      if (req_valid && req_ready) acc.push_back(e);
      @(posedge clk); #1;
      if (acc.size() == 2) req_valid = 1'b0;
      if (done) dn++;
      if (e < 2) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=0", e + 1, req_ready); end
      end
    end
    req_valid = 1'b0;
    ok = (acc.size() == 2) && (acc[0] == 0) && (acc[1] == 3);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept n=%0d got_second=%0d exp_second=3", acc.size(), acc.size() > 1 ? acc[1] : -1); end
    checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done got=%0d exp=2", dn); end
    checks++; if (reg_a !== 8'h03) begin errors++; $display("FAIL b2b_a got=%h exp=03", reg_a); end
  endtask

  task automatic test_collisions();
    int lat;
    ext_write(2'd0, 8'h01);
    do_req(OP_INC, 2'd0, 2'd0, 8'h00, 2'd0, 7'h00, 1'b1, 2'd0, 8'h55, lat);
    checks++; if (reg_a !== 8'h02) begin errors++; $display("FAIL col_a got=%h exp=02", reg_a); end
    do_req(OP_INC, 2'd0, 2'd0, 8'h00, 2'd3, MZ, 1'b1, 2'd3, 8'h7F, lat);
    checks++; if (status !== 7'h7D) begin errors++; $display("FAIL col_p got=%h exp=7d", status); end
    checks++; if (reg_a !== 8'h02) begin errors++; $display("FAIL col_a2 got=%h exp=02", reg_a); end
  endtask

  task automatic test_abort();
    int dn;
    dn = 0;
    ext_write(2'd1, 8'h44);
    ext_write(2'd3, 7'h15);
    req_op = OP_INC;
    req_src_a = 2'd1;
    req_src_b = 2'd0;
    req_dst = 2'd1;
    req_flag_mask = 7'h7F;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL abort_issue got=%b exp=0", req_ready); end
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", dn); end
    checks++; if (reg_x !== 8'h00) begin errors++; $display("FAIL abort_x got=%h exp=00", reg_x); end
    checks++; if (status !== 7'h00) begin errors++; $display("FAIL abort_p got=%h exp=00", status); end
    checks++; if (alu_a !== 8'h00) begin errors++; $display("FAIL abort_alu got=%h exp=00", alu_a); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_random();
    logic [7:0] m[0:3];
    logic [6:0] mp;
    logic [4:0] op;
    logic [1:0] sa, sb, dst, s, wbsel;
    logic [7:0] imm, d, va, vb, wbdat, er;
    logic [6:0] mask, ef;
    logic       wbwe;
    int         lat;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    mp = 7'h00;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
        ext_write(s, d);
        if (s == 2'd3) mp = d[6:0];
        else m[s] = d;
      end
      op = 5'($urandom_range(0, 9));
      sa = 2'($urandom_range(0, 3));
      sb = 2'($urandom_range(0, 3));
      dst = 2'($urandom_range(0, 3));
      imm = 8'($urandom);
      mask = 7'($urandom);
      wbwe = 1'($urandom_range(0, 1));
      wbsel = 2'($urandom_range(0, 3));
      wbdat = 8'($urandom);
      va = (sa == 2'd3) ? imm : m[sa];
      vb = (sb == 2'd3) ? imm : m[sb];
      {ef, er} = alu_fn(op, va, vb);
      do_req(op, sa, sb, imm, dst, mask, wbwe, wbsel, wbdat, lat);
      if (wbwe) begin
        if (wbsel == 2'd3) mp = wbdat[6:0];
        else m[wbsel] = wbdat;
      end
      if (dst != 2'd3) m[dst] = er;
      mp = (mp & ~mask) | (ef & mask);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rnd_lat n=%0d got=%0d exp=2", n, lat); end
      checks++; if ({alu_op, alu_a, alu_b} !== {op, va, vb}) begin errors++; $display("FAIL rnd_drive n=%0d got=%h/%h/%h exp=%h/%h/%h", n, alu_op, alu_a, alu_b, op, va, vb); end
      checks++; if ({reg_a, reg_x, reg_y, status} !== {m[0], m[1], m[2], mp}) begin errors++; $display("FAIL rnd_regs n=%0d got=%h %h %h %h exp=%h %h %h %h", n, reg_a, reg_x, reg_y, status, m[0], m[1], m[2], mp); end
    end
  endtask

  initial begin
    test_reset();
    test_asl();
    test_inc_wrap();
    test_cmp();
    test_back_to_back();
    test_collisions();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
